// File: rtl/alu_control_pipe_if.sv
// alu_control_pipe_if: instruction-in / control-out handshake bundle for alu_control_pipe
interface alu_control_pipe_if #(
  parameter int OP_W = 11,
  parameter int CTRL_W = 4
);
  logic in_valid;
  logic in_ready;
  logic [OP_W-1:0] inst31_21;
  logic [1:0] ALUOp;
  logic out_valid;
  logic out_ready;
  logic [CTRL_W-1:0] control_line;
  logic multi;
  logic busy;
  modport master (
    output in_valid, inst31_21, ALUOp, out_ready,
    input in_ready, out_valid, control_line, multi, busy
  );
  modport slave (
    input in_valid, inst31_21, ALUOp, out_ready,
    output in_ready, out_valid, control_line, multi, busy
  );
endinterface

// File: rtl/alu_control_pipe.sv
// alu_control_pipe: registered ALU-control decoder with valid/ready handshake and multi-cycle MUL hold
module alu_control_pipe #(
  parameter int OP_W = 11,
  parameter int CTRL_W = 4,
  parameter int MUL_LAT = 4
) (
  input logic clk,
  input logic reset,
  alu_control_pipe_if.slave bus
);
  localparam int CW = $clog2(MUL_LAT + 1);
  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [10:0] op;
  logic [3:0] op_code;
  logic op_mul;
  logic accept;
  assign op = bus.inst31_21[OP_W-1 -: 11];
  assign bus.in_ready = state == IDLE || (state == OUT && bus.out_ready);
  assign bus.out_valid = state == OUT;
  assign bus.busy = state == EXEC;
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    op_mul = bus.ALUOp == 2'b10 && op == 11'b10011011000;
    op_code = bus.ALUOp == 2'b00 ? 4'b0010 :
              bus.ALUOp == 2'b01 ? 4'b0111 :
              bus.ALUOp == 2'b11 ? 4'b1100 :
              op == 11'b11001011000 ? 4'b0110 :
              op == 11'b10001010000 ? 4'b0000 :
              op == 11'b10101010000 ? 4'b0001 :
              op == 11'b11010011011 ? 4'b0011 :
              op == 11'b11010011010 ? 4'b0100 :
              op == 11'b10011011000 ? 4'b1000 : 4'b0010;
  end
  always_comb begin
    next = state;
    if (state == EXEC) next = cnt == '0 ? OUT : EXEC;
    else if (accept) next = op_mul ? EXEC : OUT;
    else if (state == OUT && bus.out_ready) next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.control_line <= '0;
      bus.multi <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        bus.control_line <= CTRL_W'(op_code);
        bus.multi <= op_mul;
        cnt <= op_mul ? CW'(MUL_LAT - 1) : '0;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: doc/alu_control_pipe.md
ALU_CONTROL_PIPE -- requirements
Module: alu_control_pipe

Interface
REQ-001 SHALL have parameter OP_W, default 11, opcode field width; legal values >= 11.
REQ-002 SHALL have parameter CTRL_W, default 4, ALU control width; legal values >= 4; codes below are zero-extended to CTRL_W.
REQ-003 SHALL have parameter MUL_LAT, default 4, MUL execute cycles; legal values >= 1.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  inst31_21/ALUOp valid.
REQ-008 in_ready  output  1  block can accept an instruction this cycle.
REQ-009 inst31_21  input  OP_W  opcode field; decode uses bits [OP_W-1:OP_W-11].
REQ-010 ALUOp  input  2  main-control ALU class.
REQ-011 out_valid  output  1  control_line valid for the execute stage.
REQ-012 out_ready  input  1  execute stage consumes control_line.
REQ-013 control_line  output  CTRL_W  registered ALU control code.
REQ-014 multi  output  1  held op is multi-cycle (MUL).
REQ-015 busy  output  1  FSM in EXEC.

Function
REQ-016 Decode SHALL be: ALUOp 00 -> 0010; 01 -> 0111; 11 -> 1100; 10 -> by opcode.
REQ-017 ALUOp 10 opcode table SHALL be: 11001011000 -> 0110 (SUB); 10001010000 -> 0000 (AND); 10101010000 -> 0001 (ORR); 11010011011 -> 0011 (LSL); 11010011010 -> 0100 (LSR); 10011011000 -> 1000 (MUL, multi=1); any other -> 0010.
REQ-018 Decode SHALL be fully defined for every ALUOp/opcode combination; no latched outputs.
REQ-019 FSM states SHALL be IDLE, EXEC, OUT.
REQ-020 Accept SHALL occur when in_valid && in_ready at a rising edge; control_line and multi register on accept.
REQ-021 in_ready SHALL equal (state==IDLE) || (state==OUT && out_ready); 0 in EXEC.
REQ-022 Accepted single-cycle op SHALL go to OUT; out_valid high the next cycle (latency 1).
REQ-023 Accepted MUL SHALL go to EXEC, load counter to MUL_LAT-1, assert busy.
REQ-024 In EXEC counter SHALL decrement per cycle; at 0 go to OUT; busy high exactly MUL_LAT cycles; out_valid at accept cycle + 1 + MUL_LAT.
REQ-025 control_line and multi SHALL stay constant from accept until OUT handshake completes.
REQ-026 In OUT, out_valid SHALL stay 1 until out_ready; outputs held on stall.
REQ-027 OUT handshake with simultaneous accept SHALL load the new op back-to-back (no bubble); else go to IDLE.
REQ-028 out_valid SHALL be 0 in IDLE and EXEC.
REQ-029 Inputs other than in_valid SHALL be ignored when no accept occurs.
REQ-030 Counter width SHALL be clog2(MUL_LAT+1); no wrap in any legal configuration.

Reset
REQ-031 reset SHALL force state IDLE, control_line 0, multi 0, busy 0, out_valid 0, counter 0 at next edge.
REQ-032 reset SHALL take priority over any simultaneous handshake.
REQ-033 reset in EXEC or OUT SHALL discard the held op; no out_valid pulse follows.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 Defaults; accept ALUOp=10, op 11001011000, out_ready=1 -> next cycle out_valid=1, control_line=0110, multi=0.
REQ-036 MUL 10011011000, MUL_LAT=4 -> busy 4 cycles, in_ready 0, then out_valid=1, control_line=1000, multi=1.
REQ-037 Back-to-back ORR then AND, out_ready=1, in_valid=1 -> out_valid continuous; control_line 0001 then 0000, no bubble.
REQ-038 LSR accepted, out_ready=0 for 3 cycles -> out_valid=1, control_line=0100 held, in_ready=0; releases on out_ready=1.
REQ-039 ALUOp 11 -> 1100; ALUOp 10 unknown op 11111111111 -> 0010; ALUOp 00 / 01 -> 0010 / 0111.
REQ-040 reset asserted 2nd cycle of MUL EXEC -> next cycle all outputs 0, in_ready=1, no later out_valid.
